// File: rtl/dither_packer.sv
`default_nettype none
// ============================================================================
// Module      : dither_packer
// Description : Packs 4-pixel dithered nibbles MSB-first into NIBBLES*4-bit
//               words for the framebuffer write FIFO. A line is closed with a
//               zero-padded partial word flagged as last.
// Ports       : clk, rst        - clock, async active-high reset
//               clr_i           - sync clear of the partial word
//               in_valid_i / in_nibble_i / in_last_i / in_ready_o
//                               - nibble input handshake (pixel 0 in bit 3)
//               out_valid_o / out_data_o / out_last_o / out_count_o /
//               out_ready_i     - packed word output handshake
// Revision    : 1.0 - initial release
// ============================================================================
module dither_packer #(
  parameter int NIBBLES = 8,
  parameter int CW      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 in_valid_i,
  input  logic [3:0]           in_nibble_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  output logic [4*NIBBLES-1:0] out_data_o,
  output logic                 out_last_o,
  output logic [CW-1:0]        out_count_o,
  input  logic                 out_ready_i
);

  localparam int            OW       = 4 * NIBBLES;
  localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

  logic [OW-1:0] acc_q,       acc_d;
  logic [CW-1:0] idx_q,       idx_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q,  out_data_d;
  logic          out_last_q,  out_last_d;
  logic [CW-1:0] out_count_q, out_count_d;

  logic          w_at_end;
  logic          w_acc_en;
  logic          w_cmp;
  logic [OW-1:0] w_merged;

  assign w_at_end = (idx_q == LAST_IDX);

  // Only a completing beat needs the output register, so non-completing
  // nibbles keep flowing into the accumulator while the output is stalled.
  assign in_ready_o = ~out_valid_q | out_ready_i | (~w_at_end & ~in_last_i);

  // clr drops the nibble presented in the same cycle.
  assign w_acc_en = in_valid_i & in_ready_o & ~clr_i;
  assign w_cmp    = w_acc_en & (w_at_end | in_last_i);

  // Accumulator with the incoming nibble dropped into slot idx.
  always_comb begin
    w_merged = acc_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == CW'(i)) begin
        w_merged[OW-1-4*i -: 4] = in_nibble_i;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_count_d = out_count_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (clr_i) begin
      acc_d = '0;
      idx_d = '0;
    end else if (w_cmp) begin
      // A new word may replace the one leaving this cycle.
      out_data_d  = w_merged;
      out_count_d = idx_q + CW'(1);
      out_last_d  = in_last_i;
      out_valid_d = 1'b1;
      acc_d       = '0;
      idx_d       = '0;
    end else if (w_acc_en) begin
      acc_d = w_merged;
      idx_d = idx_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_count_o = out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dither_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dither_packer
// Description : Self-checking bench for dither_packer: directed line/stall/
//               clear/reset scenarios followed by randomized traffic, all
//               compared against a nibble-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dither_packer;

  localparam int N  = 8;
  localparam int CW = 5;
  localparam int OW = 4 * N;

  typedef struct {
    logic [OW-1:0] data;
    int            count;
    bit            last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_nibble = 4'h0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] out_count;
  logic          out_ready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: nibbles of the word being built, plus the word waiting
  // at the output.
  logic [3:0] cur[$];
  bit         m_valid = 1'b0;
  word_t      m_word;
  word_t      got[$];

  dither_packer #(.NIBBLES(N), .CW(CW)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .in_valid_i  (in_valid),
    .in_nibble_i (in_nibble),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_count_o (out_count),
    .out_ready_i (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // One cycle: drive inputs at the falling edge, check DUT against the model,
  // then advance the model by what the coming rising edge must do.
  task automatic step(input bit v, input logic [3:0] n, input bit l,
                      input bit ordy, input bit c, output bit accepted);
    bit    exp_rdy;
    word_t w;
    @(negedge clk);
    in_valid  = v;
    in_nibble = n;
    in_last   = l;
    out_ready = ordy;
    clr       = c;
    #1;
    exp_rdy = !m_valid || ordy || (cur.size() != N - 1 && !l);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", 64'(out_data), 64'(m_word.data));
      chk("out_count", 64'(out_count), 64'(m_word.count));
      chk("out_last", 64'(out_last), 64'(m_word.last));
    end
    if (out_valid && ordy) begin
      w.data  = out_data;
      w.count = int'(out_count);
      w.last  = out_last;
      got.push_back(w);
    end

    accepted = v && exp_rdy && !c;
    if (m_valid && ordy) m_valid = 1'b0;
    if (c) begin
      cur.delete();
    end else if (accepted) begin
      cur.push_back(n);
      if (cur.size() == N || l) begin
        m_word.data = '0;
        for (int k = 0; k < cur.size(); k++)
          m_word.data[OW-1-4*k -: 4] = cur[k];
        m_word.count = cur.size();
        m_word.last  = l;
        m_valid      = 1'b1;
        cur.delete();
      end
    end
  endtask

  task automatic send(input logic [3:0] n, input bit l, input bit ordy);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      step(1'b1, n, l, ordy, 1'b0, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int cycles, input bit ordy);
    bit acc;
    for (int i = 0; i < cycles; i++) step(1'b0, 4'h0, 1'b0, ordy, 1'b0, acc);
  endtask

  task automatic chk_word(input string tag, input int i, input logic [OW-1:0] d,
                          input int cnt, input bit l);
    if (got.size() > i) begin
      chk({tag, "_data"}, 64'(got[i].data), 64'(d));
      chk({tag, "_count"}, 64'(got[i].count), 64'(cnt));
      chk({tag, "_last"}, 64'(got[i].last), 64'(l));
    end
  endtask

  initial begin
    bit acc;

    // Reset state
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full word 1..8
    got.delete();
    for (int k = 1; k <= 8; k++) send(4'(k), 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("t1_words", 64'(got.size()), 64'd1);
    chk_word("t1", 0, 32'h12345678, 8, 1'b0);

    // Short lines
    got.delete();
    send(4'hA, 1'b0, 1'b1);
    send(4'hB, 1'b0, 1'b1);
    send(4'hC, 1'b1, 1'b1);
    send(4'hF, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("t2_words", 64'(got.size()), 64'd2);
    chk_word("t2a", 0, 32'hABC00000, 3, 1'b1);
    chk_word("t2b", 1, 32'hF0000000, 1, 1'b1);

    // Backpressure: second completing beat refused until out_ready rises
    got.delete();
    for (int k = 0; k < 15; k++) send(4'(k), 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, acc);
    chk("t3_refuse", 64'(in_ready), 64'd0);
    chk("t3_held", 64'(out_data), 64'h01234567);
    send(4'hF, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("t3_words", 64'(got.size()), 64'd2);
    chk_word("t3a", 0, 32'h01234567, 8, 1'b0);
    chk_word("t3b", 1, 32'h89ABCDEF, 8, 1'b0);

    // in_last on a full word: no trailing empty word
    got.delete();
    for (int k = 0; k < 8; k++) send(4'(k + 8), (k == 7), 1'b1);
    idle(3, 1'b1);
    chk("t4_words", 64'(got.size()), 64'd1);
    chk_word("t4", 0, 32'h89ABCDEF, 8, 1'b1);

    // clr discards partial word and the nibble presented with it
    got.delete();
    for (int k = 0; k < 5; k++) send(4'h3, 1'b0, 1'b1);
    step(1'b1, 4'h9, 1'b0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 8; k++) send(4'h1, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("t5_words", 64'(got.size()), 64'd1);
    chk_word("t5", 0, 32'h11111111, 8, 1'b0);

    // Asynchronous reset mid-word with a held output
    for (int k = 0; k < 8; k++) send(4'h7, 1'b0, 1'b0);
    send(4'h2, 1'b0, 1'b0);
    send(4'h2, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_count", 64'(out_count), 64'd0);
    chk("arst_last", 64'(out_last), 64'd0);
    cur.delete();
    m_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    for (int k = 0; k < 8; k++) send(4'h5, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("t6_words", 64'(got.size()), 64'd1);
    chk_word("t6", 0, 32'h55555555, 8, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 39) == 0), acc);
    end
    idle(3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
